bs_seq_controller: RTL and testbench

// - Parametrised successor controller for the bit-sliced PIM array. Sequences BRAM reads/writes, ALU op select and neighbour moves for one instruction.
// - Sits between the instruction issuer and the bit-sliced ALU/BRAM tile.
// - Adds to the previous generation: valid/ready instruction handshake and latched instruction; one-cycle done/err pulses.
// - Also adds: west moves, a border-latch cycle for all move directions, and generic LENGTH/SLICE/NREG.

---
 rtl/bs_pkg.sv | 51 +++++
 rtl/bs_seq_controller_addr_gen.sv | 20 ++
 rtl/bs_seq_controller.sv | 193 +++++++++++++++++++
 tb/tb_bs_seq_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// +--------------------------------------------------------------------------+
// | bs_pkg: opcodes, FSM states, move-mode codes and slice base helpers.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package bs_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_MV_E = 6'd5;
    localparam logic [5:0] OP_MV_W = 6'd6;
    localparam logic [5:0] OP_MV_S = 6'd7;
    localparam logic [5:0] OP_MV_N = 6'd8;
    localparam logic [5:0] OP_BADD = 6'd9;
    localparam logic [5:0] OP_BSUB = 6'd10;

    localparam logic [1:0] MV_IDLE  = 2'd0;
    localparam logic [1:0] MV_XFER  = 2'd1;
    localparam logic [1:0] MV_LATCH = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        ALU   = 3'd2,
        WB    = 3'd3,
        LATCH = 3'd4,
        DONE  = 3'd5
    } state_e;

    function automatic logic op_is_backward(input logic [5:0] op);
        return (op == OP_BADD) || (op == OP_BSUB);
    endfunction

    function automatic logic op_is_move(input logic [5:0] op);
        return (op >= OP_MV_E) && (op <= OP_MV_N);
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || op_is_backward(op) || op_is_move(op);
    endfunction

    // Backward ops walk from the MSB slice, so their base is the top word of the register.
    function automatic logic [31:0] slice_base(input logic [4:0] r, input logic backward,
                                               input int unsigned nsl);
        return (32'(r) * nsl) + (backward ? (nsl - 32'd1) : 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bs_seq_controller_addr_gen.sv
// +--------------------------------------------------------------------------+
// | bs_addr_gen: slice address = base +/- index, ADDR_W-bit unsigned.         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module bs_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic              backward_i,
    input  logic [ADDR_W-1:0] index_i,
    output logic [ADDR_W-1:0] addr_o
);

    assign addr_o = backward_i ? (base_i - index_i) : (base_i + index_i);

endmodule

`default_nettype wire

// File: rtl/bs_seq_controller.sv
// +--------------------------------------------------------------------------+
// | bs_seq_controller: sequences BRAM reads/writes, ALU select and neighbour  |
// | moves for one latched instruction of the bit-sliced PIM array. Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module bs_seq_controller
    import bs_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int SLICE  = 4,
    parameter int NREG   = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instruction_i,
    output logic [3:0]        alu_op_o,
    output logic              wea_o,
    output logic              web_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [3:0]        mv_dir_o,
    output logic [1:0]        mv_mode_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [9:0]        cycle_cnt_o
);

    localparam int unsigned NSL   = LENGTH / SLICE;
    localparam int          IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

    if (ADDR_W < $clog2(NREG * NSL)) begin : g_addr_w_check
        $error("ADDR_W too small for NREG*NSL words");
    end

    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [9:0]        cnt_q, cnt_d;

    logic              w_bwd, w_mv, w_alu, w_last;
    logic [ADDR_W-1:0] w_base_rs1, w_base_rs2, w_base_rd;
    logic [ADDR_W-1:0] w_idx_a, w_idx_b;
    logic [ADDR_W-1:0] w_rs1_addr, w_b_addr, w_rd_addr;
    logic              unused_instr;

    assign unused_instr = ^instruction_i[10:0];

    assign w_bwd = op_is_backward(op_q);
    assign w_mv  = op_is_move(op_q);
    assign w_alu = (op_q == OP_ADD) || (op_q == OP_SUB) || w_bwd;
    assign w_last = w_mv ? (idx_q == IDX_W'(NSL / 2 - 1)) : (idx_q == IDX_W'(NSL - 1));

    assign w_base_rs1 = ADDR_W'(slice_base(rs1_q, w_bwd, NSL));
    assign w_base_rs2 = w_mv ? w_base_rs1 : ADDR_W'(slice_base(rs2_q, w_bwd, NSL));
    assign w_base_rd  = ADDR_W'(slice_base(rd_q, w_bwd, NSL));

    // Moves walk word pairs (2j, 2j+1); element ops walk one slice per step.
    assign w_idx_a = w_mv ? (ADDR_W'(idx_q) << 1)          : ADDR_W'(idx_q);
    assign w_idx_b = w_mv ? ((ADDR_W'(idx_q) << 1) | ADDR_W'(1)) : ADDR_W'(idx_q);

    bs_addr_gen #(.ADDR_W(ADDR_W)) u_gen_rs1 (
        .base_i(w_base_rs1), .backward_i(w_bwd), .index_i(w_idx_a), .addr_o(w_rs1_addr)
    );
    bs_addr_gen #(.ADDR_W(ADDR_W)) u_gen_b (
        .base_i(w_base_rs2), .backward_i(w_bwd), .index_i(w_idx_b), .addr_o(w_b_addr)
    );
    bs_addr_gen #(.ADDR_W(ADDR_W)) u_gen_rd (
        .base_i(w_base_rd), .backward_i(w_bwd), .index_i(w_idx_a), .addr_o(w_rd_addr)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    op_d    = instruction_i[31:26];
                    rd_d    = instruction_i[25:21];
                    rs1_d   = instruction_i[20:16];
                    rs2_d   = instruction_i[15:11];
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = op_is_legal(instruction_i[31:26]) ? RD : DONE;
                end
            end
            RD: begin
                cnt_d   = cnt_q + 10'd1;
                state_d = w_mv ? WB : ALU;
            end
            ALU: begin
                cnt_d   = cnt_q + 10'd1;
                state_d = WB;
            end
            WB: begin
                cnt_d = cnt_q + 10'd1;
                if (w_last) begin
                    state_d = w_mv ? LATCH : DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RD;
                end
            end
            LATCH: begin
                cnt_d   = cnt_q + 10'd1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready_o = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == DONE);
        err_o         = (state_q == DONE) && !op_is_legal(op_q);
        cycle_cnt_o   = cnt_q;
        alu_op_o      = 4'h0;
        wea_o         = 1'b0;
        web_o         = 1'b0;
        addra_o       = '0;
        addrb_o       = '0;
        mv_dir_o      = 4'b0000;
        mv_mode_o     = MV_IDLE;

        if (state_q != IDLE) begin
            if (w_alu)     alu_op_o = op_q[3:0];
            else if (w_mv) alu_op_o = 4'hF;
        end

        if (w_mv && (state_q == RD || state_q == WB || state_q == LATCH)) begin
            case (op_q)
                OP_MV_E: mv_dir_o = 4'b0001;
                OP_MV_W: mv_dir_o = 4'b0010;
                OP_MV_S: mv_dir_o = 4'b0100;
                default: mv_dir_o = 4'b1000;
            endcase
        end

        case (state_q)
            RD, ALU: begin
                addra_o = w_rs1_addr;
                addrb_o = w_b_addr;
                if (w_mv) mv_mode_o = MV_XFER;
            end
            WB: begin
                addra_o = w_rd_addr;
                wea_o   = 1'b1;
                if (w_mv) begin
                    addrb_o   = w_rd_addr + ADDR_W'(1);
                    web_o     = 1'b1;
                    mv_mode_o = MV_XFER;
                end
            end
            LATCH:   mv_mode_o = MV_LATCH;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bs_seq_controller.sv
// +--------------------------------------------------------------------------+
// | tb_bs_seq_controller: directed self-checking bench for bs_seq_controller. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bs_seq_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_ready, wea, web, busy, done, err;
    logic [3:0]  alu_op, mv_dir;
    logic [9:0]  addra, addrb, cycle_cnt;
    logic [1:0]  mv_mode;

    int checks = 0;
    int errors = 0;

    bs_seq_controller dut (
        .clk_i(clk), .reset_ni(reset_n), .instr_valid_i(instr_valid),
        .instr_ready_o(instr_ready), .instruction_i(instruction), .alu_op_o(alu_op),
        .wea_o(wea), .web_o(web), .addra_o(addra), .addrb_o(addrb),
        .mv_dir_o(mv_dir), .mv_mode_o(mv_mode), .busy_o(busy), .done_o(done),
        .err_o(err), .cycle_cnt_o(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [5:0] op);
        instruction = {op, 5'd3, 5'd1, 5'd2, 11'd0};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic check_idle_after(input logic [9:0] cnt);
        check("idle_ready", instr_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_cnt", cycle_cnt, cnt);
    endtask

    // rd=3, rs1=1, rs2=2 with NSL=8: forward bases 24/8/16, backward bases 31/15/23.
    task automatic run_elem(input logic [5:0] op, input bit bwd);
        int a1, a2, aw;
        issue(op);
        for (int k = 0; k < 8; k++) begin
            a1 = bwd ? 15 - k : 8 + k;
            a2 = bwd ? 23 - k : 16 + k;
            aw = bwd ? 31 - k : 24 + k;
            check("el_rd_addra", addra, a1);
            check("el_rd_addrb", addrb, a2);
            check("el_rd_wea", wea, 0);
            check("el_alu_op", alu_op, {28'd0, op[3:0]});
            check("el_busy", busy, 1);
            check("el_ready", instr_ready, 0);
            tick();
            check("el_alu_wea", wea, 0);
            tick();
            check("el_wb_wea", wea, 1);
            check("el_wb_web", web, 0);
            check("el_wb_addra", addra, aw);
            check("el_wb_done", done, 0);
            tick();
        end
        check("el_done", done, 1);
        check("el_err", err, 0);
        check("el_done_cnt", cycle_cnt, 24);
        check("el_done_wea", wea, 0);
        check("el_done_busy", busy, 1);
        tick();
        check_idle_after(10'd24);
    endtask

    task automatic run_move(input logic [5:0] op, input logic [3:0] dir);
        issue(op);
        for (int j = 0; j < 4; j++) begin
            check("mv_rd_addra", addra, 8 + 2 * j);
            check("mv_rd_addrb", addrb, 9 + 2 * j);
            check("mv_rd_we", {wea, web}, 0);
            check("mv_rd_mode", mv_mode, 1);
            check("mv_rd_dir", mv_dir, dir);
            check("mv_alu_op", alu_op, 15);
            tick();
            check("mv_wb_addra", addra, 24 + 2 * j);
            check("mv_wb_addrb", addrb, 25 + 2 * j);
            check("mv_wb_we", {wea, web}, 3);
            check("mv_wb_mode", mv_mode, 1);
            check("mv_wb_dir", mv_dir, dir);
            tick();
        end
        check("mv_latch_mode", mv_mode, 2);
        check("mv_latch_we", {wea, web}, 0);
        check("mv_latch_dir", mv_dir, dir);
        check("mv_latch_done", done, 0);
        tick();
        check("mv_done", done, 1);
        check("mv_done_mode", mv_mode, 0);
        check("mv_done_dir", mv_dir, 0);
        check("mv_done_cnt", cycle_cnt, 9);
        tick();
        check_idle_after(10'd9);
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we", {wea, web}, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_mode", mv_mode, 0);
        reset_n = 1'b1;
        tick();

        run_elem(6'd0, 1'b0);
        run_elem(6'd9, 1'b1);
        run_move(6'd5, 4'b0001);
        run_move(6'd6, 4'b0010);

        // Illegal opcode: done+err in the cycle after accept, no writes.
        issue(6'd3);
        check("ill_done", done, 1);
        check("ill_err", err, 1);
        check("ill_we", {wea, web}, 0);
        check("ill_alu_op", alu_op, 0);
        check("ill_cnt", cycle_cnt, 0);
        tick();
        check_idle_after(10'd0);
        check("ill_err_clear", err, 0);

        // Reset in the middle of an ADD.
        issue(6'd0);
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        tick();
        check("mrst_ready", instr_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_we", {wea, web}, 0);
        check("mrst_addra", addra, 0);
        check("mrst_addrb", addrb, 0);
        check("mrst_alu_op", alu_op, 0);
        check("mrst_cnt", cycle_cnt, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_nowrite", wea, 0);
            check("mrst_stay_idle", busy, 0);
        end
        run_elem(6'd1, 1'b0);

        // instr_valid held high during a busy op: next accept only after done.
        instruction = {6'd0, 5'd3, 5'd1, 5'd2, 11'd0};
        instr_valid = 1'b1;
        tick();
        for (int c = 1; c <= 24; c++) begin
            check("hold_ready", instr_ready, 0);
            check("hold_busy", busy, 1);
            check("hold_cnt", cycle_cnt, c - 1);
            tick();
        end
        check("hold_done", done, 1);
        check("hold_done_ready", instr_ready, 0);
        tick();
        check("hold_idle_ready", instr_ready, 1);
        check("hold_idle_busy", busy, 0);
        tick();
        instr_valid = 1'b0;
        check("hold_reaccept_busy", busy, 1);
        check("hold_reaccept_cnt", cycle_cnt, 0);
        check("hold_reaccept_addra", addra, 8);
        for (int c = 0; c < 24; c++) tick();
        check("hold_second_done", done, 1);
        tick();
        check_idle_after(10'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
